// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control, registered
// one-cycle match pulse and saturating match counter.
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 16,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 16'b0000_0000_0001_0110,
  parameter int                 RST_LEN     = 5,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LW          = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               seq,
  input  logic               valid,
  input  logic               count_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   detect_count
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LW-1:0]      fill_q;

  logic [MAX_LEN-1:0] hist_d;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      len_clamp;
  logic               accept;
  logic               match;

  always_comb begin
    accept   = valid && !cfg_we;
    hist_d   = {hist_q[MAX_LEN-2:0], seq};
    fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      len_mask[i] = (i < 32'(len_q));
    len_clamp = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
    // The match is judged on the post-shift history, so the pulse lands on the
    // same edge that accepts the final pattern bit.
    match = accept && (len_q >= LW'(2)) && (fill_inc >= len_q) &&
            (((hist_d ^ pat_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat_q        <= RST_PATTERN;
      len_q        <= LW'(RST_LEN);
      ovl_q        <= RST_OVERLAP;
      hist_q       <= '0;
      fill_q       <= '0;
      detected     <= 1'b0;
      detect_count <= '0;
    end else begin
      detected <= match;
      if (cfg_we) begin
        pat_q  <= cfg_pattern;
        len_q  <= len_clamp;
        ovl_q  <= cfg_overlap;
        hist_q <= '0;
        fill_q <= '0;
      end else if (valid) begin
        hist_q <= hist_d;
        fill_q <= (match && !ovl_q) ? '0 : fill_inc;
      end
      if (count_clr)
        detect_count <= '0;
      else if (match && (detect_count != '1))
        detect_count <= detect_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the last accepted bits.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN+1);

  logic               clk = 1'b0;
  logic               resetn;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               seq;
  logic               valid;
  logic               count_clr;
  logic               detected, detected3;
  logic [15:0]        detect_count;
  logic [2:0]         detect_count3;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulse3 = 0;

  always #5 clk = ~clk;

  seq_pattern_detector dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .seq(seq), .valid(valid),
    .count_clr(count_clr), .detected(detected), .detect_count(detect_count)
  );

  seq_pattern_detector #(.CNT_W(3)) dut3 (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .seq(seq), .valid(valid),
    .count_clr(count_clr), .detected(detected3), .detect_count(detect_count3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of bits accepted since the last config/reset/consumed match.
  bit                 mq[$];
  logic [MAX_LEN-1:0] mpat = 16'b1_0110;
  int                 mlen = 5;
  bit                 movl = 1'b1;
  bit                 mdet = 1'b0;
  int                 mcnt = 0;
  int                 mcnt3 = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      mpat = 16'b1_0110; mlen = 5; movl = 1'b1; mdet = 1'b0; mcnt = 0; mcnt3 = 0;
    end else begin
      bit hit;
      hit = 1'b0;
      if (cfg_we) begin
        mpat = cfg_pattern;
        mlen = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
        movl = cfg_overlap;
        mq.delete();
      end else if (valid) begin
        mq.push_back(seq);
        if (mq.size() > MAX_LEN) void'(mq.pop_front());
        if (mlen >= 2 && mq.size() >= mlen) begin
          hit = 1'b1;
          for (int i = 0; i < mlen; i++)
            if (mq[mq.size()-1-i] != mpat[i]) hit = 1'b0;
        end
        if (hit && !movl) mq.delete();
      end
      mdet = hit;
      if (count_clr) begin
        mcnt = 0; mcnt3 = 0;
      end else if (hit) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt3 < 7) mcnt3++;
      end
      #1;
      chk("detected", 32'(detected), 32'(mdet));
      chk("detect_count", 32'(detect_count), 32'(mcnt));
      chk("detected_w3", 32'(detected3), 32'(mdet));
      chk("detect_count_w3", 32'(detect_count3), 32'(mcnt3));
    end
  end

  task automatic step(input logic s, input logic v, input logic clr);
    @(negedge clk);
    seq = s; valid = v; count_clr = clr;
    @(posedge clk); #2;
    if (detected) pulses++;
    if (detected3) pulse3++;
    valid = 1'b0; count_clr = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    @(posedge clk); #2;
    cfg_we = 1'b0;
    pulses = 0;
  endtask

  task automatic send_vec(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    resetn = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    seq = 1'b0; valid = 1'b0; count_clr = 1'b0;
    #1;
    chk("reset_detected", 32'(detected), 32'd0);
    chk("reset_count", 32'(detect_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;

    // Reset defaults reproduce the 10110 detector
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      v = 32'b10110;
      step(v[4-i], 1'b1, 1'b0);
      chk("default_no_early_pulse", 32'(detected), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("default_pulse", 32'(detected), 32'd1);
    chk("default_count", 32'(detect_count), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("pulse_one_cycle", 32'(detected), 32'd0);

    // Overlap vs non-overlap on 10110110
    load(16'b1_0110, 5'd5, 1'b1);
    send_vec(32'b1011_0110, 8);
    chk("overlap_pulses", 32'(pulses), 32'd2);
    load(16'b1_0110, 5'd5, 1'b0);
    send_vec(32'b1011_0110, 8);
    chk("nonoverlap_pulses", 32'(pulses), 32'd1);

    // 16-bit pattern with valid gaps
    load(16'hA5F0, 5'd16, 1'b1);
    v = 32'h0000_A5F0;
    for (int i = 15; i >= 0; i--) begin
      step(v[i], 1'b1, 1'b0);
      if (i == 0) chk("gap_pulse_on_last", 32'(detected), 32'd1);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("gap_pulses", 32'(pulses), 32'd1);

    // Reload mid-stream discards earlier bits
    load(16'hA5F0, 5'd16, 1'b1);
    for (int i = 15; i >= 8; i--) step(v[i], 1'b1, 1'b0);
    load(16'hA5F0, 5'd16, 1'b1);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1, 1'b0);
    chk("reload_no_pulse", 32'(pulses), 32'd0);

    // Length boundaries
    load(16'h0000, 5'd0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("len0_no_pulse", 32'(pulses), 32'd0);
    load(16'hFFFF, 5'd1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0);
    chk("len1_no_pulse", 32'(pulses), 32'd0);
    load(16'hA5F0, 5'(MAX_LEN + 5), 1'b1);
    send_vec(32'h0000_A5F0, 16);
    chk("len_clamp_pulses", 32'(pulses), 32'd1);
    load(16'b11, 5'd2, 1'b1);
    send_vec(32'b1111, 4);
    chk("len2_overlap_pulses", 32'(pulses), 32'd3);

    // Saturation: 9 matches on the 3-bit counter
    step(1'b0, 1'b0, 1'b1);
    chk("count_cleared", 32'(detect_count), 32'd0);
    load(16'b11, 5'd2, 1'b1);
    pulse3 = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("sat_matches", 32'(pulse3), 32'd9);
    chk("sat_count_w3", 32'(detect_count3), 32'd7);
    chk("count_w16", 32'(detect_count), 32'd9);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_vs_match_det", 32'(detected), 32'd1);
    chk("clr_vs_match_cnt", 32'(detect_count), 32'd0);

    // Async reset between edges, mid-pattern
    load(16'b1_0110, 5'd5, 1'b1);
    send_vec(32'b1011, 4);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_det", 32'(detected), 32'd0);
    chk("async_rst_cnt", 32'(detect_count), 32'd0);
    #1 resetn = 1'b1;
    pulses = 0;
    step(1'b0, 1'b1, 1'b0);
    chk("post_reset_no_pulse", 32'(pulses), 32'd0);
    send_vec(32'b10110, 5);
    chk("post_reset_pulse", 32'(pulses), 32'd1);

    // Randomized traffic with short patterns
    load(16'($urandom), 5'd3, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        load(16'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 99) < 2));
      end
    end

    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
